// File: rtl/byte_en_dp_ram_pipelined_if.sv
// Port bundle for byte_en_dp_ram_pipelined: two independent request/read-data ports.
// The collision line exists only when BYTE_EN_RAM_COLLISION_DETECT_EN is defined.
interface byte_en_dp_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 8192
);
  localparam int ADDR_WIDTH = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  en_a;
  logic [BE_WIDTH-1:0]   be_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic                  rd_valid_a;

  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  en_b;
  logic [BE_WIDTH-1:0]   be_b;
  logic [DATA_WIDTH-1:0] data_in_b;
  logic [DATA_WIDTH-1:0] data_out_b;
  logic                  rd_valid_b;

`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
  logic                  collision;
`endif

  modport master (
    output addr_a, en_a, be_a, data_in_a,
    output addr_b, en_b, be_b, data_in_b,
`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
    input  collision,
`endif
    input  data_out_a, rd_valid_a, data_out_b, rd_valid_b
  );

  modport slave (
    input  addr_a, en_a, be_a, data_in_a,
    input  addr_b, en_b, be_b, data_in_b,
`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
    output collision,
`endif
    output data_out_a, rd_valid_a, data_out_b, rd_valid_b
  );
endinterface

// File: rtl/byte_en_dp_ram_pipelined.sv
// True dual-port byte-enable RAM with a 1- or 2-cycle read pipeline and read-first semantics.
// Optional macro BYTE_EN_RAM_COLLISION_DETECT_EN adds a registered same-address collision flag.
module byte_en_dp_ram_pipelined #(
  parameter int    DATA_WIDTH       = 32,
  parameter int    LINES            = 8192,
  parameter int    READ_LATENCY     = 1,
  parameter int    USE_PRELOAD_FILE = 0,
  parameter string PRELOAD_FILE     = "ram_init.data"
) (
  input logic                         clk,
  input logic                         rst,
  byte_en_dp_ram_pipelined_if.slave   bus
);
  localparam int ADDR_WIDTH = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LINES_LIMIT = LINES[ADDR_WIDTH:0];

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("byte_en_dp_ram_pipelined: DATA_WIDTH must be a nonzero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("byte_en_dp_ram_pipelined: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [LINES];

  logic in_range_a, in_range_b;
  logic wr_a, wr_b, rd_a, rd_b;

  // Requests seen while rst is high are discarded; out-of-range writes are dropped.
  always_comb begin
    in_range_a = ({1'b0, bus.addr_a} < LINES_LIMIT);
    in_range_b = ({1'b0, bus.addr_b} < LINES_LIMIT);
    wr_a = !rst && bus.en_a && (|bus.be_a) && in_range_a;
    wr_b = !rst && bus.en_b && (|bus.be_b) && in_range_b;
    rd_a = !rst && bus.en_a && !(|bus.be_a);
    rd_b = !rst && bus.en_b && !(|bus.be_b);
  end

  // Port B's byte lanes are assigned last so they win a same-address, same-byte collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_a && bus.be_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.data_in_a[8*i +: 8];
      if (wr_b && bus.be_b[i]) mem[bus.addr_b][8*i +: 8] <= bus.data_in_b[8*i +: 8];
    end
  end

  logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;
  logic                  s1_valid_a, s1_valid_b;

  // First read register samples the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_a  <= '0;
      s1_valid_a <= 1'b0;
    end else begin
      s1_valid_a <= rd_a;
      if (rd_a) s1_data_a <= in_range_a ? mem[bus.addr_a] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_b  <= '0;
      s1_valid_b <= 1'b0;
    end else begin
      s1_valid_b <= rd_b;
      if (rd_b) s1_data_b <= in_range_b ? mem[bus.addr_b] : '0;
    end
  end

  logic [DATA_WIDTH-1:0] q_data_a, q_data_b;
  logic                  q_valid_a, q_valid_b;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_a, s2_data_b;
    logic                  s2_valid_a, s2_valid_b;

    // Output stage only loads on a completing read so data_out holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_a  <= '0;
        s2_data_b  <= '0;
        s2_valid_a <= 1'b0;
        s2_valid_b <= 1'b0;
      end else begin
        s2_valid_a <= s1_valid_a;
        s2_valid_b <= s1_valid_b;
        if (s1_valid_a) s2_data_a <= s1_data_a;
        if (s1_valid_b) s2_data_b <= s1_data_b;
      end
    end

    assign q_data_a  = s2_data_a;
    assign q_data_b  = s2_data_b;
    assign q_valid_a = s2_valid_a;
    assign q_valid_b = s2_valid_b;
  end else begin : g_lat1
    assign q_data_a  = s1_data_a;
    assign q_data_b  = s1_data_b;
    assign q_valid_a = s1_valid_a;
    assign q_valid_b = s1_valid_b;
  end

  // Masking with rst keeps outputs quiet during the reset cycle itself, dropping in-flight reads.
  assign bus.data_out_a = rst ? '0 : q_data_a;
  assign bus.data_out_b = rst ? '0 : q_data_b;
  assign bus.rd_valid_a = q_valid_a & ~rst;
  assign bus.rd_valid_b = q_valid_b & ~rst;

`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.collision <= 1'b0;
    end else begin
      bus.collision <= bus.en_a && bus.en_b && (bus.addr_a == bus.addr_b) &&
                       ((|bus.be_a) || (|bus.be_b));
    end
  end
`endif

endmodule

// File: tb/tb_byte_en_dp_ram_pipelined.sv
// Bench for byte_en_dp_ram_pipelined: table vectors, directed corner sequences and a random
// phase checked by a queue-based reference model; a second instance exercises READ_LATENCY=2.
module tb_byte_en_dp_ram_pipelined;
  localparam int DW  = 32;
  localparam int LN  = 12;
  localparam int AW  = 4;
  localparam int BW  = 4;
  localparam int DW2 = 64;
  localparam int LN2 = 16;
  localparam int AW2 = 4;
  localparam int BW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  byte_en_dp_ram_pipelined_if #(.DATA_WIDTH(DW),  .LINES(LN))  bus  ();
  byte_en_dp_ram_pipelined_if #(.DATA_WIDTH(DW2), .LINES(LN2)) bus2 ();

  byte_en_dp_ram_pipelined #(.DATA_WIDTH(DW), .LINES(LN), .READ_LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  byte_en_dp_ram_pipelined #(.DATA_WIDTH(DW2), .LINES(LN2), .READ_LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: array contents plus per-port queues of reads due at a given cycle.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend [2][$];
  logic [DW-1:0] mdl_mem [16];
  logic [DW-1:0] hold [2] = '{'0, '0};
  logic          exp_col = 1'b0;
  string         vname [2] = '{"valid_a", "valid_b"};
  string         dname [2] = '{"dout_a", "dout_b"};

  always @(negedge clk) begin : model
    logic          en [2];
    logic [BW-1:0] be [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] di [2];
    logic [DW-1:0] dq [2];
    logic          vl [2];
    logic          exp_v;
    pend_t         e;
    en[0] = bus.en_a;       en[1] = bus.en_b;
    be[0] = bus.be_a;       be[1] = bus.be_b;
    ad[0] = bus.addr_a;     ad[1] = bus.addr_b;
    di[0] = bus.data_in_a;  di[1] = bus.data_in_b;
    dq[0] = bus.data_out_a; dq[1] = bus.data_out_b;
    vl[0] = bus.rd_valid_a; vl[1] = bus.rd_valid_b;
    for (int p = 0; p < 2; p++) begin
      exp_v = 1'b0;
      if (rst) begin
        pend[p].delete();
        hold[p] = '0;
      end else if (pend[p].size() > 0 && pend[p][0].due == cyc) begin
        e = pend[p].pop_front();
        exp_v = 1'b1;
        hold[p] = e.data;
      end
      checkOutput(vname[p], 64'(vl[p]), 64'(exp_v));
      checkOutput(dname[p], 64'(dq[p]), 64'(hold[p]));
    end
`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
    checkOutput("collision", 64'(bus.collision), 64'(exp_col));
    exp_col = !rst && en[0] && en[1] && (ad[0] == ad[1]) && ((be[0] != 0) || (be[1] != 0));
`endif
    if (!rst) begin
      for (int p = 0; p < 2; p++)
        if (en[p] && be[p] == 0)
          pend[p].push_back('{cyc + 1, (ad[p] < LN) ? mdl_mem[ad[p]] : '0});
      for (int p = 0; p < 2; p++)
        if (en[p] && be[p] != 0 && ad[p] < LN)
          for (int i = 0; i < BW; i++)
            if (be[p][i]) mdl_mem[ad[p]][8*i +: 8] = di[p][8*i +: 8];
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en_a = 1'b0;
    bus.en_b = 1'b0;
  endtask

  task automatic applyStimulus(input bit port_b, input logic [AW-1:0] addr,
                               input logic [BW-1:0] be, input logic [DW-1:0] data);
    if (port_b) begin
      bus.en_b = 1'b1; bus.addr_b = addr; bus.be_b = be; bus.data_in_b = data;
    end else begin
      bus.en_a = 1'b1; bus.addr_a = addr; bus.be_a = be; bus.data_in_a = data;
    end
  endtask

  task automatic readA(input logic [AW-1:0] addr, input string name, input logic [DW-1:0] expected);
    int waited = 0;
    idle();
    applyStimulus(1'b0, addr, '0, '0);
    tick();
    idle();
    while (!bus.rd_valid_a && waited < 4) begin
      tick();
      waited++;
    end
    checkOutput({name, "_valid"}, 64'(bus.rd_valid_a), 64'd1);
    checkOutput(name, 64'(bus.data_out_a), 64'(expected));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] pre;
    bit            port_b;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expected;
  } vec_t;

  vec_t vecs [6];

  logic [DW2-1:0] v2 [3];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'd5,  32'h00000000, 1'b0, 4'hF,    32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{4'd9,  32'h11223344, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h11BB33DD};
    vecs[2] = '{4'd2,  32'hFFFFFFFF, 1'b0, 4'b1000, 32'h12345678, 32'h12FFFFFF};
    vecs[3] = '{4'd4,  32'h01020304, 1'b1, 4'b0000, 32'h55555555, 32'h01020304};
    vecs[4] = '{4'd11, 32'h00000000, 1'b0, 4'b0110, 32'hCAFEF00D, 32'h00FEF000};
    vecs[5] = '{4'd13, 32'h77777777, 1'b1, 4'hF,    32'h88888888, 32'h00000000};
    v2[0] = 64'h0123456789ABCDEF;
    v2[1] = 64'hFEDCBA9876543210;
    v2[2] = 64'hA5A5A5A55A5A5A5A;

    rst = 1'b1;
    rst2 = 1'b1;
    bus.en_a = 1'b0; bus.en_b = 1'b0;
    bus.addr_a = '0; bus.addr_b = '0; bus.be_a = '0; bus.be_b = '0;
    bus.data_in_a = '0; bus.data_in_b = '0;
    bus2.en_a = 1'b0; bus2.en_b = 1'b0;
    bus2.addr_a = '0; bus2.addr_b = '0; bus2.be_a = '0; bus2.be_b = '0;
    bus2.data_in_a = '0; bus2.data_in_b = '0;
    $display("[TB] start");
    tick();
    tick();
    checkOutput("rst_dout_a", 64'(bus.data_out_a), 64'd0);
    checkOutput("rst_valid_a", 64'(bus.rd_valid_a), 64'd0);
    checkOutput("rst_dout_b", 64'(bus.data_out_b), 64'd0);
    checkOutput("rst_valid_b", 64'(bus.rd_valid_b), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      idle();
      applyStimulus(1'b0, AW'(i), '1, DW'(i) * 32'h01010101);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      idle();
      applyStimulus(1'b0, vecs[i].addr, '1, vecs[i].pre);
      tick();
      idle();
      applyStimulus(vecs[i].port_b, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      tick();
      readA(vecs[i].addr, $sformatf("vec%0d", i), vecs[i].expected);
      tick();
      checkOutput($sformatf("vec%0d_pulse", i), 64'(bus.rd_valid_a), 64'd0);
      checkOutput($sformatf("vec%0d_hold", i), 64'(bus.data_out_a), 64'(vecs[i].expected));
    end

    idle();
    applyStimulus(1'b0, 4'd3, 4'hF, 32'h00000000);
    applyStimulus(1'b1, 4'd3, 4'b0011, 32'h0000FFFF);
    tick();
    idle();
`ifdef BYTE_EN_RAM_COLLISION_DETECT_EN
    checkOutput("collision_pulse", 64'(bus.collision), 64'd1);
`endif
    readA(4'd3, "collide", 32'h0000FFFF);

    idle();
    applyStimulus(1'b0, 4'd7, 4'hF, 32'h00000001);
    tick();
    idle();
    applyStimulus(1'b0, 4'd7, 4'h0, 32'h0);
    applyStimulus(1'b1, 4'd7, 4'hF, 32'h00000002);
    tick();
    idle();
    checkOutput("rf_valid", 64'(bus.rd_valid_a), 64'd1);
    checkOutput("rf_old", 64'(bus.data_out_a), 64'h1);
    readA(4'd7, "rf_new", 32'h00000002);

    applyStimulus(1'b0, 4'd5, 4'h0, 32'h0);
    tick();
    checkOutput("b2b0", 64'(bus.data_out_a), 64'hDEADBEEF);
    applyStimulus(1'b0, 4'd9, 4'h0, 32'h0);
    tick();
    checkOutput("b2b1", 64'(bus.data_out_a), 64'h11BB33DD);
    checkOutput("b2b1_valid", 64'(bus.rd_valid_a), 64'd1);
    idle();
    tick();
    checkOutput("b2b_end_valid", 64'(bus.rd_valid_a), 64'd0);

    applyStimulus(1'b0, 4'd2, 4'h0, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rstmid_valid", 64'(bus.rd_valid_a), 64'd0);
    checkOutput("rstmid_dout", 64'(bus.data_out_a), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rstpost_valid", 64'(bus.rd_valid_a), 64'd0);
      tick();
    end
    readA(4'd5, "rstpost_5", 32'hDEADBEEF);
    readA(4'd9, "rstpost_9", 32'h11BB33DD);

    for (int k = 0; k < 400; k++) begin
      bus.en_a = 1'($urandom_range(0, 1));
      bus.en_b = 1'($urandom_range(0, 1));
      bus.addr_a = AW'($urandom_range(0, 15));
      bus.addr_b = ($urandom_range(0, 3) == 0) ? bus.addr_a : AW'($urandom_range(0, 15));
      bus.be_a = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
      bus.be_b = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
      bus.data_in_a = $urandom;
      bus.data_in_b = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus2.en_b = 1'b1; bus2.addr_b = AW2'(i); bus2.be_b = '1; bus2.data_in_b = v2[i];
      tick();
    end
    bus2.en_b = 1'b0;
    tick();
    for (int s = 1; s <= 5; s++) begin
      if (s <= 3) begin
        bus2.en_a = 1'b1; bus2.addr_a = AW2'(s - 1); bus2.be_a = '0;
      end else begin
        bus2.en_a = 1'b0;
      end
      tick();
      checkOutput($sformatf("lat2_valid%0d", s), 64'(bus2.rd_valid_a), (s >= 2 && s <= 4) ? 64'd1 : 64'd0);
      checkOutput($sformatf("lat2_data%0d", s), bus2.data_out_a,
                  (s < 2) ? 64'd0 : v2[(s - 2 > 2) ? 2 : s - 2]);
    end

    bus2.en_b = 1'b1; bus2.addr_b = 4'd0; bus2.be_b = BW2'(8'b10000001); bus2.data_in_b = '1;
    tick();
    bus2.en_b = 1'b0;
    bus2.en_a = 1'b1; bus2.addr_a = 4'd0; bus2.be_a = '0;
    tick();
    bus2.en_a = 1'b0;
    tick();
    checkOutput("lat2_merge_valid", 64'(bus2.rd_valid_a), 64'd1);
    checkOutput("lat2_merge", bus2.data_out_a, 64'hFF23456789ABCDFF);

    bus2.en_a = 1'b1; bus2.addr_a = 4'd1; bus2.be_a = '0;
    tick();
    bus2.en_a = 1'b0;
    rst2 = 1'b1;
    #1;
    checkOutput("lat2_rst_valid", 64'(bus2.rd_valid_a), 64'd0);
    checkOutput("lat2_rst_dout", bus2.data_out_a, 64'd0);
    tick();
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("lat2_rstpost_valid", 64'(bus2.rd_valid_a), 64'd0);
      checkOutput("lat2_rstpost_dout", bus2.data_out_a, 64'd0);
      tick();
    end
    bus2.en_a = 1'b1; bus2.addr_a = 4'd1; bus2.be_a = '0;
    tick();
    bus2.en_a = 1'b0;
    tick();
    checkOutput("lat2_after_valid", 64'(bus2.rd_valid_a), 64'd1);
    checkOutput("lat2_after_data", bus2.data_out_a, v2[1]);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
